// File: rtl/bcd_score_counter_pkg.sv
// Shared constants and types for the four-digit BCD score counter.
package bcd_score_counter_pkg;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] BCD_ZERO      = 4'd0;
  localparam int         NUM_DIGITS    = 4;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_INC  = 2'd1,
    OP_DEC  = 2'd2
  } countOpT;

endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit that counts up or down when its carry/borrow input
// allows it, and reports a carry/borrow to the next more significant digit.
module bcd_digit
  import bcd_score_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       up,
  input  logic       down,
  input  logic       cin,
  input  logic       bin,
  output logic [3:0] q,
  output logic       cout,
  output logic       bout
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= BCD_ZERO;
    end else if (up && cin) begin
      q <= (q == BCD_MAX_DIGIT) ? BCD_ZERO : q + 4'd1;
    end else if (down && bin) begin
      q <= (q == BCD_ZERO) ? BCD_MAX_DIGIT : q - 4'd1;
    end
  end

  // Carry/borrow are combinational so they ripple through all digits in one cycle.
  assign cout = up && cin && (q == BCD_MAX_DIGIT);
  assign bout = down && bin && (q == BCD_ZERO);

endmodule

// File: rtl/bcd_score_counter.sv
// Four-digit BCD up/down score counter with optional saturation at 9999/0000
// and a one-cycle overflow pulse.
module bcd_score_counter
  import bcd_score_counter_pkg::*;
#(
  parameter bit SAT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       atMax,
  output logic       atZero,
  output logic       ovf
);

  logic [3:0]          q [NUM_DIGITS];
  logic [NUM_DIGITS:0] carry;
  logic [NUM_DIGITS:0] borrow;
  countOpT             op;
  logic                upperNine, upperZero;
  logic                allNine, allZero, nearMax, nearZero;
  logic                upEff, downEff;
  logic                atMaxNext, atZeroNext, ovfNext;

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : genDigit
    bcd_digit uDigit (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .up   (upEff),
      .down (downEff),
      .cin  (carry[i]),
      .bin  (borrow[i]),
      .q    (q[i]),
      .cout (carry[i+1]),
      .bout (borrow[i+1])
    );
  end

  always_comb begin
    upperNine = 1'b1;
    upperZero = 1'b1;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      upperNine = upperNine && (q[i] == BCD_MAX_DIGIT);
      upperZero = upperZero && (q[i] == BCD_ZERO);
    end
    allNine  = upperNine && (q[0] == BCD_MAX_DIGIT);
    allZero  = upperZero && (q[0] == BCD_ZERO);
    nearMax  = upperNine && (q[0] == BCD_MAX_DIGIT - 4'd1);
    nearZero = upperZero && (q[0] == 4'd1);
  end

  // Saturation blocks the digit chain at the end stops; wrap lets it roll over.
  always_comb begin
    op = OP_HOLD;
    if (inc && !dec)      op = OP_INC;
    else if (dec && !inc) op = OP_DEC;
    upEff   = (op == OP_INC) && !(SAT_EN && allNine);
    downEff = (op == OP_DEC) && !(SAT_EN && allZero);
  end

  // Flags look at the value the digits will hold after this edge.
  always_comb begin
    atMaxNext  = (upEff && nearMax) || borrow[NUM_DIGITS] ||
                 (!upEff && !downEff && allNine);
    atZeroNext = (downEff && nearZero) || carry[NUM_DIGITS] ||
                 (!upEff && !downEff && allZero);
    ovfNext    = ((op == OP_INC) && allNine) || ((op == OP_DEC) && allZero);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      atMax  <= 1'b0;
      atZero <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      atMax  <= atMaxNext;
      atZero <= atZeroNext;
      ovf    <= ovfNext;
    end
  end

  assign digit0 = q[0];
  assign digit1 = q[1];
  assign digit2 = q[2];
  assign digit3 = q[3];

endmodule
